// File: rtl/hs_fifo_buffer.sv
// Valid/ready FIFO buffer with registered handshake outputs and one-cycle latency.
// Optional occupancy output `level` is enabled by defining HS_FIFO_LEVEL_EN.
module hs_fifo_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef HS_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en;
  logic              rd_en;

  // Handshake flags come only from the registered count (plus reset), so a
  // read on a full edge cannot open room for a write on that same edge.
  assign s_ready = !rst && (count != FULL);
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];

  assign wr_en = s_valid && s_ready;
  assign rd_en = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; wr_en is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

`ifdef HS_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_hs_fifo_buffer.sv
// Self-checking bench: directed vector table on a DEPTH=4 instance, random
// backpressure on a DEPTH=2/DATA_W=8 instance against a queue model.
module tb_hs_fifo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: DATA_W=32, DEPTH=4
  logic        a_rst, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [31:0] a_s_data, a_m_data;
`ifdef HS_FIFO_LEVEL_EN
  logic [2:0]  a_level;
`endif

  hs_fifo_buffer #(.DATA_W(32), .DEPTH(4)) dut_a (
    .clk     (clk),
    .rst     (a_rst),
    .s_valid (a_s_valid),
    .s_ready (a_s_ready),
    .s_data  (a_s_data),
    .m_valid (a_m_valid),
    .m_ready (a_m_ready),
    .m_data  (a_m_data)
`ifdef HS_FIFO_LEVEL_EN
    ,
    .level   (a_level)
`endif
  );

  // Instance B: DATA_W=8, DEPTH=2
  logic       b_rst, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [7:0] b_s_data, b_m_data;
`ifdef HS_FIFO_LEVEL_EN
  logic [1:0] b_level;
`endif

  hs_fifo_buffer #(.DATA_W(8), .DEPTH(2)) dut_b (
    .clk     (clk),
    .rst     (b_rst),
    .s_valid (b_s_valid),
    .s_ready (b_s_ready),
    .s_data  (b_s_data),
    .m_valid (b_m_valid),
    .m_ready (b_m_ready),
    .m_data  (b_m_data)
`ifdef HS_FIFO_LEVEL_EN
    ,
    .level   (b_level)
`endif
  );

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        exp_sr;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic        chk_md;
    logic [2:0]  exp_lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic sv, input logic [31:0] sd,
                        input logic mr, input logic exp_sr, input logic exp_mv,
                        input logic [31:0] exp_md, input logic chk_md,
                        input logic [2:0] exp_lvl);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
    v.exp_sr = exp_sr; v.exp_mv = exp_mv; v.exp_md = exp_md;
    v.chk_md = chk_md; v.exp_lvl = exp_lvl;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are then sampled mid-cycle.
  task automatic applyStimulus(input logic rst, input logic sv,
                               input logic [31:0] sd, input logic mr);
    @(negedge clk);
    a_rst = rst; a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic exp_sr, input logic exp_mv,
                        input logic [31:0] exp_md, input logic chk_md,
                        input logic [2:0] exp_lvl);
    checkOutput({tag, " s_ready"}, 32'(a_s_ready), 32'(exp_sr));
    checkOutput({tag, " m_valid"}, 32'(a_m_valid), 32'(exp_mv));
    if (chk_md) checkOutput({tag, " m_data"}, a_m_data, exp_md);
`ifdef HS_FIFO_LEVEL_EN
    checkOutput({tag, " level"}, 32'(a_level), 32'(exp_lvl));
`endif
  endtask

  logic [7:0] q[$];
  int  next_in;
  int  out_cnt;
  int  cyc;
  logic wr, rd;

  initial begin
    a_rst = 1'b1; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_rst = 1'b1; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;

    // Each row: inputs for the cycle, and outputs visible during that cycle.
    //      rst sv sd  mr  sr mv md  chk lvl
    for (int i = 0; i < 5; i++)
      addVec(1, 1, 99, 0,  0, 0, 0,  0, 0);
    addVec(0, 0, 0,  0,  1, 0, 0,  0, 0);
    addVec(0, 1, 55, 1,  1, 0, 0,  0, 0);
    addVec(0, 1, 56, 1,  1, 1, 55, 1, 1);
    addVec(0, 1, 57, 1,  1, 1, 56, 1, 1);
    addVec(0, 0, 0,  1,  1, 1, 57, 1, 1);
    addVec(0, 0, 0,  0,  1, 0, 0,  0, 0);
    addVec(0, 1, 60, 0,  1, 0, 0,  0, 0);
    addVec(0, 1, 61, 0,  1, 1, 60, 1, 1);
    addVec(0, 1, 62, 0,  1, 1, 60, 1, 2);
    addVec(0, 1, 63, 0,  1, 1, 60, 1, 3);
    addVec(0, 1, 64, 0,  0, 1, 60, 1, 4);
    addVec(0, 1, 64, 0,  0, 1, 60, 1, 4);
    addVec(0, 1, 64, 1,  0, 1, 60, 1, 4);
    addVec(0, 1, 64, 1,  1, 1, 61, 1, 3);
    addVec(0, 0, 0,  1,  1, 1, 62, 1, 3);
    addVec(0, 0, 0,  1,  1, 1, 63, 1, 2);
    addVec(0, 0, 0,  1,  1, 1, 64, 1, 1);
    addVec(0, 0, 0,  0,  1, 0, 0,  0, 0);
    addVec(0, 1, 70, 0,  1, 0, 0,  0, 0);
    addVec(1, 1, 71, 1,  0, 1, 70, 1, 1);
    addVec(0, 0, 0,  1,  1, 0, 0,  0, 0);

    // One unchecked reset edge so registered state is defined.
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].mr);
      checkA($sformatf("vec%0d", i), vecs[i].exp_sr, vecs[i].exp_mv,
             vecs[i].exp_md, vecs[i].chk_md, vecs[i].exp_lvl);
    end

    // Mid-operation reset: stored entries must vanish for good.
    applyStimulus(0, 1, 80, 0);
    applyStimulus(0, 1, 81, 0);
    applyStimulus(0, 1, 82, 0);
    applyStimulus(0, 0, 0, 0);
    checkA("mid three stored", 1, 1, 80, 1, 3);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkA("mid after reset", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 90, 1);
    checkA("mid write new", 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkA("mid new head", 1, 1, 90, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkA("mid drained", 1, 0, 0, 0, 0);

    // Random valid/ready on the DEPTH=2 instance against a queue model.
    @(negedge clk);
    b_rst = 1'b0;
    #1;
    checkOutput("rand init s_ready", 32'(b_s_ready), 32'd1);
    checkOutput("rand init m_valid", 32'(b_m_valid), 32'd0);
    next_in = 0;
    out_cnt = 0;
    cyc     = 0;
    while (out_cnt < 100 && cyc < 4000) begin
      @(negedge clk);
      b_s_valid = (next_in < 100) && ($urandom_range(0, 1) == 1);
      b_s_data  = 8'(next_in);
      b_m_ready = ($urandom_range(0, 2) != 0);
      #1;
      checkOutput("rand s_ready", 32'(b_s_ready), 32'(q.size() < 2));
      checkOutput("rand m_valid", 32'(b_m_valid), 32'(q.size() > 0));
      if (q.size() > 0) checkOutput("rand m_data", 32'(b_m_data), 32'(q[0]));
      @(posedge clk);
      wr = b_s_valid && (q.size() < 2);
      rd = b_m_ready && (q.size() > 0);
      if (rd) begin
        void'(q.pop_front());
        out_cnt++;
      end
      if (wr) begin
        q.push_back(8'(next_in));
        next_in++;
      end
      cyc++;
    end
    checkOutput("rand beats delivered", 32'(out_cnt), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
